re_flow_pipe_ctrl: RTL and testbench

RE_FLOW_PIPE_CTRL -- requirements
Module: re_flow_pipe_ctrl

---
 rtl/re_flow_pipe_ctrl_if.sv | 25 ++
 rtl/re_flow_pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_re_flow_pipe_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/re_flow_pipe_ctrl_if.sv
// Handshake bundle between the optical-flow pipeline controller and its
// upstream tensor source / downstream velocity sink.
interface re_flow_pipe_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport master (
        output in_valid,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_last
    );
endinterface

// File: rtl/re_flow_pipe_ctrl.sv
// Frame-level flow controller for a fixed-latency optical-flow pipeline:
// tracks valid beats through the pipe, counts pixels, stalls on backpressure.
module re_flow_pipe_ctrl #(
    parameter int PIPE_LATENCY = 142,
    parameter int CNT_WIDTH    = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_pixels,
    re_flow_pipe_ctrl_if.slave   flow,
    output logic                 pipe_en,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [PIPE_LATENCY-1:0] VLD_ONE  = {{(PIPE_LATENCY-1){1'b0}}, 1'b1};
    localparam logic [PIPE_LATENCY-1:0] VLD_ZERO = {PIPE_LATENCY{1'b0}};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PIPE_LATENCY-1:0] vld_r;
    logic [CNT_WIDTH-1:0]    in_cnt_r;
    logic [CNT_WIDTH-1:0]    out_cnt_r;
    logic [CNT_WIDTH-1:0]    count_r;
    logic                    done_r;
    logic                    done_nxt_s;

    logic busy_s;
    logic out_valid_s;
    logic pipe_en_s;
    logic in_ready_s;
    logic out_last_s;
    logic in_hs_s;
    logic out_hs_s;
    logic start_ok_s;

    // Handshake qualifiers; one stalled output freezes the entire pipe
    assign busy_s      = (state_r != ST_IDLE);
    assign out_valid_s = vld_r[PIPE_LATENCY-1];
    assign pipe_en_s   = busy_s && (!out_valid_s || flow.out_ready);
    assign in_ready_s  = (state_r == ST_RUN) && pipe_en_s && (in_cnt_r < count_r);
    assign out_last_s  = out_valid_s && (out_cnt_r == (count_r - CNT_ONE));
    assign in_hs_s     = flow.in_valid && in_ready_s;
    assign out_hs_s    = out_valid_s && flow.out_ready;
    assign start_ok_s  = (state_r == ST_IDLE) && start;

    assign flow.in_ready  = in_ready_s;
    assign flow.out_valid = out_valid_s;
    assign flow.out_last  = out_last_s;
    assign pipe_en        = pipe_en_s;
    assign busy           = busy_s;
    assign done           = done_r;

    // Next-state and completion-pulse decode
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (num_pixels != CNT_ZERO)) begin
                    state_nxt_s = ST_RUN;
                end else if (start) begin
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_hs_s && ((in_cnt_r + CNT_ONE) == count_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s && out_last_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counters, valid shift register and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            vld_r     <= VLD_ZERO;
            in_cnt_r  <= CNT_ZERO;
            out_cnt_r <= CNT_ZERO;
            count_r   <= CNT_ZERO;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            if (start_ok_s) begin
                count_r   <= num_pixels;
                in_cnt_r  <= CNT_ZERO;
                out_cnt_r <= CNT_ZERO;
            end else begin
                if (in_hs_s) begin
                    in_cnt_r <= in_cnt_r + CNT_ONE;
                end
                if (out_hs_s) begin
                    out_cnt_r <= out_cnt_r + CNT_ONE;
                end
            end
            // Idle cycles with no accepted input still shift, leaving a bubble
            if (pipe_en_s) begin
                vld_r <= (vld_r << 1) | (in_hs_s ? VLD_ONE : VLD_ZERO);
            end
        end
    end

endmodule

// File: tb/tb_re_flow_pipe_ctrl.sv
// Directed bench for re_flow_pipe_ctrl with PIPE_LATENCY=4: per-cycle vectors
// compare {in_ready, pipe_en, out_valid, out_last, busy, done}.
module tb_re_flow_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] num_pixels;
    logic        pipe_en;
    logic        busy;
    logic        done;

    int errors;
    int checks;
    int beats;
    int dones;

    re_flow_pipe_ctrl_if flow_if ();

    re_flow_pipe_ctrl #(.PIPE_LATENCY(4), .CNT_WIDTH(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_pixels (num_pixels),
        .flow       (flow_if),
        .pipe_en    (pipe_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [19:0] num;
        logic        iv;
        logic        ordy;
        logic [5:0]  exp;   // {in_ready, pipe_en, out_valid, out_last, busy, done}
    } vec_t;

    vec_t tab [17];

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, advances past the edge
    task automatic cyc(input logic r, input logic s, input logic [19:0] n,
                       input logic iv, input logic ordy, input logic [5:0] exp,
                       input string name);
        logic [5:0] got;
        rst = r;
        start = s;
        num_pixels = n;
        flow_if.in_valid = iv;
        flow_if.out_ready = ordy;
        #1;
        got = {flow_if.in_ready, pipe_en, flow_if.out_valid, flow_if.out_last, busy, done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (ir,pe,ov,last,busy,done)", name, got, exp);
        end
        if (flow_if.out_valid && ordy && !r) beats++;
        if (done) dones++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        beats  = 0;
        dones  = 0;

        // Frame of 3 with start held during RUN, then a back-to-back frame of 2
        tab[0]  = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b000000};
        tab[1]  = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b110010};
        tab[2]  = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b110010};
        tab[3]  = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b110010};
        tab[4]  = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b010010};
        tab[5]  = '{1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011010};
        tab[6]  = '{1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011010};
        tab[7]  = '{1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011110};
        tab[8]  = '{1'b0, 1'b1, 20'd2, 1'b1, 1'b1, 6'b000001};
        tab[9]  = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b110010};
        tab[10] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b110010};
        tab[11] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b010010};
        tab[12] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b010010};
        tab[13] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b011010};
        tab[14] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b011110};
        tab[15] = '{1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b000001};
        tab[16] = '{1'b0, 1'b0, 20'd2, 1'b0, 1'b1, 6'b000000};

        rst = 1'b1;
        start = 1'b0;
        num_pixels = 20'd0;
        flow_if.in_valid = 1'b0;
        flow_if.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 6'b000000, "reset_state");

        beats = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(tab[i].rst, tab[i].start, tab[i].num, tab[i].iv, tab[i].ordy,
                tab[i].exp, $sformatf("table_c%0d", i));
        end
        check_val("table_beats", beats, 5);

        // Backpressure on the first output beat
        beats = 0;
        cyc(1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b000000, "bp_c0");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "bp_c1");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "bp_c2");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "bp_c3");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b010010, "bp_c4");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b0, 6'b001010, "bp_c5_stall");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011010, "bp_c6_held");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011010, "bp_c7");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011110, "bp_c8_last");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b000001, "bp_c9_done");
        check_val("bp_beats", beats, 3);

        // Two-cycle input bubble; c5 has simultaneous input and output handshakes
        beats = 0;
        cyc(1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b000000, "bub_c0");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "bub_c1");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b110010, "bub_c2");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b110010, "bub_c3");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "bub_c4");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b111010, "bub_c5_both");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b010010, "bub_c6_gap");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b010010, "bub_c7_gap");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b011010, "bub_c8");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b011110, "bub_c9_last");
        cyc(1'b0, 1'b0, 20'd3, 1'b0, 1'b1, 6'b000001, "bub_c10_done");
        check_val("bub_beats", beats, 3);

        // Empty frame
        dones = 0;
        cyc(1'b0, 1'b1, 20'd0, 1'b1, 1'b1, 6'b000000, "zero_c0");
        cyc(1'b0, 1'b0, 20'd0, 1'b1, 1'b1, 6'b000001, "zero_c1_done");
        cyc(1'b0, 1'b0, 20'd0, 1'b1, 1'b1, 6'b000000, "zero_c2");
        cyc(1'b0, 1'b0, 20'd0, 1'b1, 1'b1, 6'b000000, "zero_c3");
        check_val("zero_dones", dones, 1);

        // Reset in DRAIN with beats in flight, reset beating start, then a frame of 2
        cyc(1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 6'b000000, "rst_c0");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "rst_c1");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "rst_c2");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b110010, "rst_c3");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b010010, "rst_c4");
        cyc(1'b1, 1'b0, 20'd3, 1'b1, 1'b1, 6'b011010, "rst_c5_assert");
        cyc(1'b1, 1'b1, 20'd3, 1'b1, 1'b1, 6'b000000, "rst_c6_cleared");
        cyc(1'b0, 1'b0, 20'd3, 1'b1, 1'b1, 6'b000000, "rst_c7_idle");
        beats = 0;
        dones = 0;
        cyc(1'b0, 1'b1, 20'd2, 1'b1, 1'b1, 6'b000000, "rst_c8_start");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b110010, "rst_c9");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b110010, "rst_c10");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b010010, "rst_c11");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b010010, "rst_c12");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b011010, "rst_c13");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b011110, "rst_c14_last");
        cyc(1'b0, 1'b0, 20'd2, 1'b1, 1'b1, 6'b000001, "rst_c15_done");
        check_val("rst_frame_beats", beats, 2);
        check_val("rst_frame_dones", dones, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
